// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional write-to-read bypass
// and a per-register busy scoreboard for multi-cycle producers.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              wr0_ok;
    logic              wr1_ok;

    assign wr0_ok = we0 && ((ZERO_REG == 0) || (wa0 != '0));
    assign wr1_ok = we1 && ((ZERO_REG == 0) || (wa1 != '0));

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_ok) regs[wa0] <= wd0;
            if (wr1_ok) regs[wa1] <= wd1;
        end
    end

    // A reserve is applied after the write clears so a new producer supersedes the old one.
    always_comb begin
        busy_next = busy;
        if (we0)    busy_next[wa0]      = 1'b0;
        if (we1)    busy_next[wa1]      = 1'b0;
        if (rsv_en) busy_next[rsv_addr] = 1'b1;
        if (ZERO_REG != 0) busy_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + CNT_W'(busy_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              is_zero;
        logic              hit0;
        logic              hit1;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign ra      = rd_addr[k*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);
        assign hit0    = we0 && (wa0 == ra);
        assign hit1    = we1 && (wa1 == ra);

        // Outputs are forced to 0 during reset so bypassed write data cannot leak out.
        always_comb begin
            data = regs[ra];
            bsy  = busy[ra];
            if (BYPASS != 0) begin
                if (hit1)      data = wd1;
                else if (hit0) data = wd0;
                bsy = busy[ra] && !(hit0 || hit1);
            end
            if (!rst_n || is_zero) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k]                  = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one bypassing 32x32 instance and one
// non-bypassing 8x16 four-read-port instance, checked against an array model.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Index 0 drives the bypassing instance, index 1 the small non-bypassing one.
    logic [4:0]  rd_addr_v  [2][4];
    logic        we0_v      [2];
    logic        we1_v      [2];
    logic        rsv_en_v   [2];
    logic [4:0]  wa0_v      [2];
    logic [4:0]  wa1_v      [2];
    logic [4:0]  rsv_addr_v [2];
    logic [31:0] wd0_v      [2];
    logic [31:0] wd1_v      [2];

    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [5:0]  a_busy_cnt;
    logic [11:0] b_rd_addr;
    logic [63:0] b_rd_data;
    logic [3:0]  b_rd_busy;
    logic [3:0]  b_busy_cnt;

    assign a_rd_addr = {rd_addr_v[0][1], rd_addr_v[0][0]};
    assign b_rd_addr = {rd_addr_v[1][3][2:0], rd_addr_v[1][2][2:0],
                        rd_addr_v[1][1][2:0], rd_addr_v[1][0][2:0]};

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .we0(we0_v[0]), .wa0(wa0_v[0]), .wd0(wd0_v[0]),
        .we1(we1_v[0]), .wa1(wa1_v[0]), .wd1(wd1_v[0]),
        .rsv_en(rsv_en_v[0]), .rsv_addr(rsv_addr_v[0]),
        .busy_cnt(a_busy_cnt)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .we0(we0_v[1]), .wa0(wa0_v[1][2:0]), .wd0(wd0_v[1][15:0]),
        .we1(we1_v[1]), .wa1(wa1_v[1][2:0]), .wd1(wd1_v[1][15:0]),
        .rsv_en(rsv_en_v[1]), .rsv_addr(rsv_addr_v[1][2:0]),
        .busy_cnt(b_busy_cnt)
    );

    typedef struct {
        int          d;
        logic [63:0] data;
        logic [3:0]  busy;
        logic [5:0]  cnt;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mreg  [2][32];
    bit          mbusy [2][32];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [4:0] amask(input int d);
        return (d == 0) ? 5'h1f : 5'h07;
    endfunction

    function automatic logic [31:0] dmask(input int d);
        return (d == 0) ? 32'hffff_ffff : 32'h0000_ffff;
    endfunction

    function automatic int nrd(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int dw(input int d);
        return (d == 0) ? 32 : 16;
    endfunction

    function automatic logic [4:0] rand_addr(input int d);
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31)) & amask(d);
    endfunction

    function automatic int count_busy(input int d);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[d][i]);
        return n;
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [4:0] a_in, output logic bsy);
        logic [4:0] a;
        logic       byp;
        logic       hit0;
        logic       hit1;
        a    = a_in & amask(d);
        byp  = (d == 0);
        hit0 = we0_v[d] && ((wa0_v[d] & amask(d)) == a);
        hit1 = we1_v[d] && ((wa1_v[d] & amask(d)) == a);
        bsy  = 1'b0;
        if (!rst_n || a == 5'd0) return 32'd0;
        bsy = mbusy[d][a] && !(byp && (hit0 || hit1));
        if (byp && hit1) return wd1_v[d] & dmask(d);
        if (byp && hit0) return wd0_v[d] & dmask(d);
        return mreg[d][a];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) begin
                mreg[d][i]  = 32'd0;
                mbusy[d][i] = 1'b0;
            end
        end
    endtask

    task automatic commit(input int d);
        logic [4:0] a0;
        logic [4:0] a1;
        logic [4:0] ar;
        a0 = wa0_v[d] & amask(d);
        a1 = wa1_v[d] & amask(d);
        ar = rsv_addr_v[d] & amask(d);
        if (we0_v[d] && a0 != 5'd0) mreg[d][a0] = wd0_v[d] & dmask(d);
        if (we1_v[d] && a1 != 5'd0) mreg[d][a1] = wd1_v[d] & dmask(d);
        if (we0_v[d]) mbusy[d][a0] = 1'b0;
        if (we1_v[d]) mbusy[d][a1] = 1'b0;
        if (rsv_en_v[d] && ar != 5'd0) mbusy[d][ar] = 1'b1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) rd_addr_v[d][k] = 5'd0;
            we0_v[d] = 1'b0;  wa0_v[d] = 5'd0;  wd0_v[d] = 32'd0;
            we1_v[d] = 1'b0;  wa1_v[d] = 5'd0;  wd1_v[d] = 32'd0;
            rsv_en_v[d] = 1'b0;  rsv_addr_v[d] = 5'd0;
        end
    endtask

    task automatic rand_inputs(input int d);
        for (int k = 0; k < 4; k++) rd_addr_v[d][k] = rand_addr(d);
        we0_v[d] = 1'($urandom_range(0, 1));
        wa0_v[d] = rand_addr(d);
        wd0_v[d] = $urandom & dmask(d);
        we1_v[d] = 1'($urandom_range(0, 1));
        wa1_v[d] = rand_addr(d);
        wd1_v[d] = $urandom & dmask(d);
        rsv_en_v[d]   = ($urandom_range(0, 2) == 0);
        rsv_addr_v[d] = rand_addr(d);
        if ($urandom_range(0, 3) == 0) wa1_v[d] = wa0_v[d];
        if ($urandom_range(0, 3) == 0) rsv_addr_v[d] = wa0_v[d];
        if ($urandom_range(0, 2) == 0) rd_addr_v[d][0] = wa0_v[d];
        if ($urandom_range(0, 2) == 0) rd_addr_v[d][1] = wa1_v[d];
    endtask

    // Called at posedge+1 with inputs already driven; the expectation covers this cycle.
    task automatic applyStimulus(input int d, input string tag);
        exp_t        e;
        logic [31:0] v;
        logic        b;
        e.d    = d;
        e.data = 64'd0;
        e.busy = 4'd0;
        e.tag  = tag;
        for (int k = 0; k < nrd(d); k++) begin
            v = model_read(d, rd_addr_v[d][k], b);
            e.data = e.data | (64'(v) << (k * dw(d)));
            e.busy[k] = b;
        end
        e.cnt = rst_n ? 6'(count_busy(d)) : 6'd0;
        sb_q.push_back(e);
        @(posedge clk);
        if (rst_n) commit(d);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [63:0] act_data;
        logic [3:0]  act_busy;
        logic [5:0]  act_cnt;
        act_data = (e.d == 0) ? a_rd_data : b_rd_data;
        act_busy = (e.d == 0) ? {2'b00, a_rd_busy} : b_rd_busy;
        act_cnt  = (e.d == 0) ? a_busy_cnt : {2'b00, b_busy_cnt};
        checks++;
        if (act_data !== e.data) begin
            errors++;
            $display("[TB] FAIL %s rd_data: got %h, expected %h", e.tag, act_data, e.data);
        end
        checks++;
        if (act_busy !== e.busy) begin
            errors++;
            $display("[TB] FAIL %s rd_busy: got %b, expected %b", e.tag, act_busy, e.busy);
        end
        checks++;
        if (act_cnt !== e.cnt) begin
            errors++;
            $display("[TB] FAIL %s busy_cnt: got %0d, expected %0d", e.tag, act_cnt, e.cnt);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) checkOutput(sb_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_all();
        model_reset();
        @(posedge clk);
        #1;
        rd_addr_v[0][0] = 5'd5;  rd_addr_v[0][1] = 5'd10;
        applyStimulus(0, "reset_a");
        rd_addr_v[1][0] = 5'd3;  rd_addr_v[1][3] = 5'd7;
        applyStimulus(1, "reset_b");
        rst_n = 1'b1;

        idle_all(); we0_v[0] = 1'b1; wa0_v[0] = 5'd0; wd0_v[0] = 32'h1234;
        applyStimulus(0, "zero_wr");
        idle_all();
        applyStimulus(0, "zero_rd");

        idle_all(); we0_v[0] = 1'b1; wa0_v[0] = 5'd5; wd0_v[0] = 32'hDEAD_BEEF; rd_addr_v[0][0] = 5'd5;
        applyStimulus(0, "r5_wr");
        idle_all(); rd_addr_v[0][0] = 5'd5; rd_addr_v[0][1] = 5'd6; rsv_en_v[0] = 1'b1; rsv_addr_v[0] = 5'd6;
        applyStimulus(0, "r5_rd_rsv_r6");
        idle_all(); rd_addr_v[0][0] = 5'd5; rd_addr_v[0][1] = 5'd6;
        applyStimulus(0, "r6_busy");
        rst_n = 1'b0;
        model_reset();
        we0_v[0] = 1'b1; wa0_v[0] = 5'd5; wd0_v[0] = 32'hFFFF_FFFF;
        applyStimulus(0, "reset_mid");
        applyStimulus(0, "reset_hold");
        rst_n = 1'b1;
        idle_all(); rd_addr_v[0][0] = 5'd5; rd_addr_v[0][1] = 5'd6;
        applyStimulus(0, "after_reset");

        idle_all(); we0_v[0] = 1'b1; wa0_v[0] = 5'd7; wd0_v[0] = 32'h1111_1111;
        we1_v[0] = 1'b1; wa1_v[0] = 5'd7; wd1_v[0] = 32'h2222_2222; rd_addr_v[0][0] = 5'd7;
        applyStimulus(0, "dual_same");
        idle_all(); rd_addr_v[0][0] = 5'd7;
        applyStimulus(0, "dual_same_rd");
        idle_all(); we0_v[0] = 1'b1; wa0_v[0] = 5'd3; wd0_v[0] = 32'h3333_0003;
        we1_v[0] = 1'b1; wa1_v[0] = 5'd4; wd1_v[0] = 32'h4444_0004;
        rd_addr_v[0][0] = 5'd3; rd_addr_v[0][1] = 5'd4;
        applyStimulus(0, "dual_diff");
        idle_all(); rd_addr_v[0][0] = 5'd3; rd_addr_v[0][1] = 5'd4;
        applyStimulus(0, "dual_diff_rd");

        idle_all(); we0_v[0] = 1'b1; wa0_v[0] = 5'd9; wd0_v[0] = 32'hA5A5_A5A5; rd_addr_v[0][0] = 5'd9;
        applyStimulus(0, "bypass_r9");
        idle_all(); rd_addr_v[0][0] = 5'd9;
        applyStimulus(0, "bypass_r9_rd");

        idle_all(); rsv_en_v[0] = 1'b1; rsv_addr_v[0] = 5'd10; rd_addr_v[0][0] = 5'd10;
        applyStimulus(0, "rsv_r10");
        idle_all(); rd_addr_v[0][0] = 5'd10;
        applyStimulus(0, "busy_r10");
        applyStimulus(0, "busy_r10_hold1");
        applyStimulus(0, "busy_r10_hold2");
        we1_v[0] = 1'b1; wa1_v[0] = 5'd10; wd1_v[0] = 32'h55;
        applyStimulus(0, "clr_r10");
        idle_all(); rd_addr_v[0][0] = 5'd10;
        applyStimulus(0, "cnt_r10");

        idle_all(); rsv_en_v[0] = 1'b1; rsv_addr_v[0] = 5'd12;
        applyStimulus(0, "rsv_r12");
        idle_all(); rsv_en_v[0] = 1'b1; rsv_addr_v[0] = 5'd12;
        we0_v[0] = 1'b1; wa0_v[0] = 5'd12; wd0_v[0] = 32'h0000_CAFE; rd_addr_v[0][0] = 5'd12;
        applyStimulus(0, "coll_r12");
        idle_all(); rd_addr_v[0][0] = 5'd12;
        applyStimulus(0, "coll_r12_after");

        for (int n = 0; n < 300; n++) begin
            idle_all();
            rand_inputs(0);
            applyStimulus(0, "rand_a");
        end

        idle_all(); we0_v[1] = 1'b1; wa0_v[1] = 5'd5; wd0_v[1] = 32'h0000_A5A5; rd_addr_v[1][0] = 5'd5;
        applyStimulus(1, "nobyp_wr");
        idle_all(); rd_addr_v[1][0] = 5'd5;
        applyStimulus(1, "nobyp_rd");

        for (int i = 0; i < 4; i++) begin
            idle_all();
            we0_v[1] = 1'b1; wa0_v[1] = 5'(2 * i);     wd0_v[1] = $urandom & 32'hffff;
            we1_v[1] = 1'b1; wa1_v[1] = 5'(2 * i + 1); wd1_v[1] = $urandom & 32'hffff;
            for (int k = 0; k < 4; k++) rd_addr_v[1][k] = rand_addr(1);
            applyStimulus(1, "fill_b");
        end
        for (int i = 0; i < 3; i++) begin
            idle_all();
            for (int k = 0; k < 4; k++) rd_addr_v[1][k] = rand_addr(1);
            applyStimulus(1, "read4_b");
        end
        for (int i = 0; i < 8; i++) begin
            idle_all();
            rsv_en_v[1] = 1'b1; rsv_addr_v[1] = 5'(i);
            for (int k = 0; k < 4; k++) rd_addr_v[1][k] = 5'((i + k) % 8);
            applyStimulus(1, "rsv_all_b");
        end
        idle_all();
        for (int k = 0; k < 4; k++) rd_addr_v[1][k] = 5'(k + 4);
        applyStimulus(1, "cnt_full_b");

        for (int n = 0; n < 200; n++) begin
            idle_all();
            rand_inputs(1);
            applyStimulus(1, "rand_b");
        end

        idle_all();
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
